mc_sequencer: RTL

MC_SEQUENCER -- requirements
Module: mc_sequencer

---
 rtl/rv32_pkg.sv | 52 +++++
 rtl/seq_op_classify.sv | 30 +++
 rtl/mc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 opcode constants, opcode-class enum and the
// multi-cycle sequencer state enum.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } op_class_e;

    // Encoding is visible on the state port, so keep it explicit.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } seq_state_e;

    // Classes whose second ALU operand is the immediate.
    function automatic logic cls_uses_imm(input op_class_e c);
        return (c == CLS_I) || (c == CLS_LOAD) || (c == CLS_STORE) ||
               (c == CLS_JALR) || (c == CLS_LUI) || (c == CLS_AUIPC);
    endfunction

    // Classes that write a result back to the register file.
    function automatic logic cls_writes_rd(input op_class_e c);
        return (c == CLS_R) || (c == CLS_I) || (c == CLS_LOAD) ||
               (c == CLS_LUI) || (c == CLS_AUIPC) || (c == CLS_JAL) ||
               (c == CLS_JALR);
    endfunction

endpackage

// File: rtl/seq_op_classify.sv
// seq_op_classify: combinational opcode -> class map.
//   opcode   in  7  instruction[6:0]
//   op_class out    decoded class (CLS_NONE when unrecognised)
//   illegal  out 1  opcode is not one of the supported classes
module seq_op_classify
    import rv32_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       illegal
);

    always_comb begin
        op_class = CLS_NONE;
        case (opcode)
            OP_R:      op_class = CLS_R;
            OP_I:      op_class = CLS_I;
            OP_LOAD:   op_class = CLS_LOAD;
            OP_STORE:  op_class = CLS_STORE;
            OP_BRANCH: op_class = CLS_BRANCH;
            OP_JAL:    op_class = CLS_JAL;
            OP_JALR:   op_class = CLS_JALR;
            OP_LUI:    op_class = CLS_LUI;
            OP_AUIPC:  op_class = CLS_AUIPC;
            default:   op_class = CLS_NONE;  // includes SYSTEM 1110011
        endcase
        illegal = (op_class == CLS_NONE);
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle RV32 control sequencer.
//   clk, rst            clock, synchronous active-high reset
//   en                  run enable (level); sampled in IDLE and WB only
//   opcode              instruction[6:0], valid from DECODE onward
//   br_taken            branch result, used in WB
//   mem_ack             one-cycle memory completion pulse (FETCH/MEM only)
//   fetch_req           instruction fetch request (FETCH)
//   instr_latch         strobe on the FETCH cycle that sees mem_ack
//   mem_read/mem_write  data request held through MEM
//   reg_write_en        register write enable (WB)
//   alu_src, mem_to_reg datapath mux selects
//   pc_load, pc_inc     PC update strobes in WB, mutually exclusive
//   illegal             high while trapped; only rst clears it
//   state               current state encoding
//   retired             retired instruction count, wraps at 16 bits
module mc_sequencer
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        fetch_req,
    output logic        instr_latch,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write_en,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        pc_load,
    output logic        pc_inc,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    seq_state_e  st_q, st_d;
    op_class_e   cls_q, cls_dec;
    logic        dec_illegal;
    logic [15:0] retired_q;

    seq_op_classify u_classify (
        .opcode   (opcode),
        .op_class (cls_dec),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q      <= S_IDLE;
            cls_q     <= CLS_NONE;
            retired_q <= '0;
        end else begin
            st_q <= st_d;
            if (st_q == S_DECODE)
                cls_q <= cls_dec;
            if (st_q == S_WB)
                retired_q <= retired_q + 16'd1;
        end
    end

    // Next state. en is only looked at in IDLE and WB, so dropping it
    // mid-instruction lets the instruction run to completion.
    always_comb begin
        st_d = st_q;
        case (st_q)
            S_IDLE:   if (en) st_d = S_FETCH;
            S_FETCH:  if (mem_ack) st_d = S_DECODE;
            S_DECODE: st_d = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC:   st_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEM : S_WB;
            S_MEM:    if (mem_ack) st_d = S_WB;
            S_WB:     st_d = en ? S_FETCH : S_IDLE;
            S_TRAP:   st_d = S_TRAP;
            default:  st_d = S_IDLE;
        endcase
    end

    // Outputs come from state and the latched class; instr_latch and the
    // PC strobes additionally qualify on the input they report on.
    always_comb begin
        fetch_req    = 1'b0;
        instr_latch  = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        reg_write_en = 1'b0;
        alu_src      = 1'b0;
        mem_to_reg   = 1'b0;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;
        case (st_q)
            S_FETCH: begin
                fetch_req   = 1'b1;
                instr_latch = mem_ack;
            end
            S_EXEC: alu_src = cls_uses_imm(cls_q);
            S_MEM: begin
                mem_read  = (cls_q == CLS_LOAD);
                mem_write = (cls_q == CLS_STORE);
            end
            S_WB: begin
                reg_write_en = cls_writes_rd(cls_q);
                mem_to_reg   = (cls_q == CLS_LOAD);
                pc_load      = (cls_q == CLS_JAL) || (cls_q == CLS_JALR) ||
                               ((cls_q == CLS_BRANCH) && br_taken);
                pc_inc       = !pc_load;
            end
            default: ;
        endcase
    end

    // TRAP is left only through rst, so the state itself is the sticky flag.
    assign illegal = (st_q == S_TRAP);
    assign state   = st_q;
    assign retired = retired_q;

endmodule
